// File: rtl/xadc_drp_pkg.sv
// Shared types and constants for the XADC DRP read arbiter.
package xadc_drp_pkg;

  localparam int DRP_DATA_W = 16;
  localparam int DRP_ADDR_W = 7;

  localparam logic [DRP_ADDR_W-1:0] DRP_ADDR_TEMP   = 7'h00;
  localparam logic [DRP_ADDR_W-1:0] DRP_ADDR_VCCINT = 7'h01;
  localparam logic [DRP_ADDR_W-1:0] DRP_ADDR_AUX15  = 7'h1F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } drp_state_e;

  // Next round-robin start index: the slot after idx, wrapping at n.
  function automatic int rr_wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/xadc_drp_arbiter_if.sv
// Requester and XADC DRP signal bundle; slave is the arbiter side, master the environment.
interface xadc_drp_arbiter_if
  import xadc_drp_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0][DRP_ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0]                 rsp_valid;
  logic [DRP_DATA_W-1:0]              rsp_data;
  logic                               rsp_err;

  logic                               drp_den;
  logic [DRP_ADDR_W-1:0]              drp_daddr;
  logic                               drp_dwe;
  logic [DRP_DATA_W-1:0]              drp_di;
  logic [DRP_DATA_W-1:0]              drp_do;
  logic                               drp_drdy;

  modport slave (
    input  req_valid, req_addr, drp_do, drp_drdy,
    output req_ready, rsp_valid, rsp_data, rsp_err,
           drp_den, drp_daddr, drp_dwe, drp_di
  );

  modport master (
    output req_valid, req_addr, drp_do, drp_drdy,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
           drp_den, drp_daddr, drp_dwe, drp_di
  );

endinterface

// File: rtl/xadc_drp_arbiter_rr_arbiter.sv
// Combinational round-robin selector: first active request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xadc_drp_arbiter.sv
// Round-robin arbiter sharing one XADC DRP read port among NUM_REQ requesters.
// Define XADC_DRP_TIMEOUT_EN to bound WAIT with an error response after TIMEOUT_CYCLES.
module xadc_drp_arbiter
  import xadc_drp_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  xadc_drp_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("xadc_drp_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  drp_state_e            state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    winner_q, winner_d;
  logic [DRP_ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_REQ-1:0]    ready_q, ready_d;
  logic                  den_q, den_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DRP_DATA_W-1:0] data_q, data_d;

  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i   (bus.req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

`ifdef XADC_DRP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_hit;
  logic             err_q, err_d;

  assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counts WAIT cycles; the count is cleared while the read is being issued.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == ISSUE) begin
      wait_cnt_d = '0;
    end else if (state_q == WAIT && !timeout_hit) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  // All handshake outputs are registered, so each lands one cycle after the
  // state that produced it: ready in ISSUE, den in the first WAIT cycle, rsp_valid in RESP.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    winner_d    = winner_q;
    addr_d      = addr_q;
    ready_d     = '0;
    den_d       = 1'b0;
    rsp_valid_d = '0;
    data_d      = data_q;
`ifdef XADC_DRP_TIMEOUT_EN
    err_d       = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          ready_d  = grant;
          winner_d = grant;
          addr_d   = bus.req_addr[grant_idx];
          ptr_d    = IDX_W'(rr_wrap_inc(int'(grant_idx), NUM_REQ));
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        den_d   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.drp_drdy) begin
          data_d      = bus.drp_do;
          rsp_valid_d = winner_q;
`ifdef XADC_DRP_TIMEOUT_EN
          err_d       = 1'b0;
`endif
          state_d     = RESP;
        end
`ifdef XADC_DRP_TIMEOUT_EN
        else if (timeout_hit) begin
          data_d      = '0;
          rsp_valid_d = winner_q;
          err_d       = 1'b1;
          state_d     = RESP;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      winner_q    <= '0;
      addr_q      <= '0;
      ready_q     <= '0;
      den_q       <= 1'b0;
      rsp_valid_q <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      winner_q    <= winner_d;
      addr_q      <= addr_d;
      ready_q     <= ready_d;
      den_q       <= den_d;
      rsp_valid_q <= rsp_valid_d;
      data_q      <= data_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = data_q;
  assign bus.drp_den   = den_q;
  assign bus.drp_daddr = addr_q;
  assign bus.drp_dwe   = 1'b0;
  assign bus.drp_di    = '0;

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// Directed self-checking bench for xadc_drp_arbiter; covers XADC_DRP_TIMEOUT_EN when defined.
module tb_xadc_drp_arbiter;
  import xadc_drp_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  xadc_drp_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  xadc_drp_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, limit 100000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Drives one read through the arbiter and returns what was observed at each step.
  task automatic run_txn(input logic [NUM_REQ-1:0] valid, input int drdy_dly,
                         input logic [15:0] data,
                         output logic [NUM_REQ-1:0] got_ready, output int ready_lat,
                         output logic [6:0] got_addr, output int den_cnt,
                         output logic [NUM_REQ-1:0] got_rsp, output logic [15:0] got_data,
                         output logic got_err, output logic [NUM_REQ-1:0] got_after);
    bus.req_valid = valid;
    got_ready = '0;
    ready_lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        got_ready = bus.req_ready;
        ready_lat = i;
        break;
      end
    end
    bus.req_valid = '0;
    den_cnt = 0;
    @(negedge clk);
    got_addr = bus.drp_daddr;
    if (bus.drp_den) den_cnt++;
    for (int i = 0; i < drdy_dly; i++) begin
      @(negedge clk);
      if (bus.drp_den) den_cnt++;
    end
    bus.drp_drdy = 1'b1;
    bus.drp_do   = data;
    @(negedge clk);
    bus.drp_drdy = 1'b0;
    got_rsp  = bus.rsp_valid;
    got_data = bus.rsp_data;
    got_err  = bus.rsp_err;
    @(negedge clk);
    got_after = bus.rsp_valid;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.req_ready !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_req_ready: got %b expected 0000", bus.req_ready);
    end
    vectors++;
    if (bus.rsp_valid !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_rsp_valid: got %b expected 0000", bus.rsp_valid);
    end
    vectors++;
    if ({bus.drp_den, bus.drp_daddr} !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_drp: got den=%b addr=%h expected den=0 addr=00", bus.drp_den, bus.drp_daddr);
    end
    vectors++;
    if ({bus.rsp_data, bus.rsp_err} !== 17'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_rsp: got data=%h err=%b expected data=0000 err=0", bus.rsp_data, bus.rsp_err);
    end
    vectors++;
    if ({bus.drp_dwe, bus.drp_di} !== 17'h0) begin
      miscompares++;
      $display("[TB] FAIL tied_write: got dwe=%b di=%h expected 0/0000", bus.drp_dwe, bus.drp_di);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [NUM_REQ-1:0] rdy, rsp, aft;
    logic [6:0] addr;
    logic [15:0] data;
    logic err;
    int lat, dens;
    bus.req_addr[0] = DRP_ADDR_AUX15;
    run_txn(4'b0001, 5, 16'h8000, rdy, lat, addr, dens, rsp, data, err, aft);
    vectors++;
    if (rdy !== 4'b0001 || lat != 1) begin
      miscompares++;
      $display("[TB] FAIL single_ready: got %b after %0d cycles expected 0001 after 1", rdy, lat);
    end
    vectors++;
    if (addr !== 7'h1F || dens != 1) begin
      miscompares++;
      $display("[TB] FAIL single_den: got addr=%h pulses=%0d expected addr=1f pulses=1", addr, dens);
    end
    vectors++;
    if (rsp !== 4'b0001 || aft !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL single_rsp_valid: got %b then %b expected 0001 then 0000", rsp, aft);
    end
    vectors++;
    if (data !== 16'h8000 || err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_rsp_data: got %h err=%b expected 8000 err=0", data, err);
    end
    vectors++;
    if (bus.drp_daddr !== 7'h1F) begin
      miscompares++;
      $display("[TB] FAIL single_daddr_hold: got %h expected 1f", bus.drp_daddr);
    end
  endtask

  task automatic test_fairness();
    logic [NUM_REQ-1:0] rdy, rsp, aft, exp_g;
    logic [6:0] addr;
    logic [15:0] data;
    logic err;
    int lat, dens;
    pulse_reset();
    for (int r = 0; r < NUM_REQ; r++) bus.req_addr[r] = 7'(7'h10 + r);
    for (int k = 0; k < 8; k++) begin
      exp_g = 4'b0001 << (k % 4);
      run_txn(4'b1111, 1, 16'(16'h1000 + k), rdy, lat, addr, dens, rsp, data, err, aft);
      vectors++;
      if (rdy !== exp_g) begin
        miscompares++;
        $display("[TB] FAIL fair_grant[%0d]: got %b expected %b", k, rdy, exp_g);
      end
      vectors++;
      if (addr !== 7'(7'h10 + (k % 4))) begin
        miscompares++;
        $display("[TB] FAIL fair_addr[%0d]: got %h expected %h", k, addr, 7'(7'h10 + (k % 4)));
      end
      vectors++;
      if (rsp !== exp_g || data !== 16'(16'h1000 + k)) begin
        miscompares++;
        $display("[TB] FAIL fair_rsp[%0d]: got %b/%h expected %b/%h", k, rsp, data, exp_g, 16'(16'h1000 + k));
      end
    end
  endtask

  task automatic test_repeat_winner();
    logic [NUM_REQ-1:0] rdy, rsp, aft;
    logic [6:0] addr;
    logic [15:0] data;
    logic err;
    int lat, dens;
    for (int k = 0; k < 2; k++) begin
      run_txn(4'b1000, 2, 16'hA5A5, rdy, lat, addr, dens, rsp, data, err, aft);
      vectors++;
      if (rdy !== 4'b1000 || rsp !== 4'b1000 || addr !== 7'h13) begin
        miscompares++;
        $display("[TB] FAIL repeat_winner[%0d]: got grant=%b rsp=%b addr=%h expected 1000/1000/13", k, rdy, rsp, addr);
      end
    end
  endtask

  task automatic test_spurious_drdy();
    logic bad;
    bus.drp_drdy = 1'b1;
    bus.drp_do   = 16'hFFFF;
    bad = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.rsp_valid !== 4'b0000 || bus.rsp_data !== 16'hA5A5) bad = 1'b1;
    end
    bus.drp_drdy = 1'b0;
    vectors++;
    if (bad) begin
      miscompares++;
      $display("[TB] FAIL spurious_idle: got rsp_valid=%b data=%h expected 0000/a5a5", bus.rsp_valid, bus.rsp_data);
    end
    bus.req_addr[2] = DRP_ADDR_VCCINT;
    bus.req_valid   = 4'b0100;
    @(negedge clk);
    bus.req_valid = '0;
    vectors++;
    if (bus.req_ready !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL spurious_grant: got %b expected 0100", bus.req_ready);
    end
    bus.drp_drdy = 1'b1;
    bus.drp_do   = 16'hDEAD;
    @(negedge clk);
    bus.drp_drdy = 1'b0;
    vectors++;
    if (bus.drp_den !== 1'b1 || bus.drp_daddr !== 7'h01) begin
      miscompares++;
      $display("[TB] FAIL spurious_den: got den=%b addr=%h expected 1/01", bus.drp_den, bus.drp_daddr);
    end
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid !== 4'b0000 || bus.rsp_data !== 16'hA5A5) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("[TB] FAIL spurious_issue: got rsp_valid=%b data=%h expected 0000/a5a5", bus.rsp_valid, bus.rsp_data);
    end
    bus.drp_drdy = 1'b1;
    bus.drp_do   = 16'h0123;
    @(negedge clk);
    bus.drp_drdy = 1'b0;
    vectors++;
    if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 16'h0123) begin
      miscompares++;
      $display("[TB] FAIL spurious_recover: got %b/%h expected 0100/0123", bus.rsp_valid, bus.rsp_data);
    end
    @(negedge clk);
  endtask

`ifdef XADC_DRP_TIMEOUT_EN
  task automatic test_timeout();
    logic early;
    bus.req_addr[1] = DRP_ADDR_TEMP;
    for (int pass = 0; pass < 2; pass++) begin
      bus.req_valid = 4'b0010;
      @(negedge clk);
      bus.req_valid = '0;
      @(negedge clk);
      early = 1'b0;
      for (int k = 1; k < TIMEOUT; k++) begin
        @(negedge clk);
        if (bus.rsp_valid !== 4'b0000) early = 1'b1;
        if (pass == 1 && k == TIMEOUT - 1) begin
          bus.drp_drdy = 1'b1;
          bus.drp_do   = 16'hBEEF;
        end
      end
      @(negedge clk);
      bus.drp_drdy = 1'b0;
      vectors++;
      if (early) begin
        miscompares++;
        $display("[TB] FAIL timeout_early[%0d]: rsp_valid before cycle %0d", pass, TIMEOUT);
      end
      vectors++;
      if (pass == 0 && {bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {4'b0010, 1'b1, 16'h0000}) begin
        miscompares++;
        $display("[TB] FAIL timeout_rsp: got %b err=%b data=%h expected 0010 err=1 data=0000", bus.rsp_valid, bus.rsp_err, bus.rsp_data);
      end
      if (pass == 1 && {bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {4'b0010, 1'b0, 16'hBEEF}) begin
        miscompares++;
        $display("[TB] FAIL timeout_terminal_drdy: got %b err=%b data=%h expected 0010 err=0 data=beef", bus.rsp_valid, bus.rsp_err, bus.rsp_data);
      end
      @(negedge clk);
    end
  endtask
`else
  task automatic test_no_timeout();
    logic bad;
    bus.req_addr[1] = DRP_ADDR_TEMP;
    bus.req_valid   = 4'b0010;
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    bad = 1'b0;
    for (int k = 1; k <= TIMEOUT + 4; k++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 4'b0000 || bus.rsp_err !== 1'b0) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("[TB] FAIL no_timeout_wait: got rsp_valid=%b err=%b expected 0000/0", bus.rsp_valid, bus.rsp_err);
    end
    bus.drp_drdy = 1'b1;
    bus.drp_do   = 16'hBEEF;
    @(negedge clk);
    bus.drp_drdy = 1'b0;
    vectors++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {4'b0010, 1'b0, 16'hBEEF}) begin
      miscompares++;
      $display("[TB] FAIL no_timeout_rsp: got %b err=%b data=%h expected 0010 err=0 data=beef", bus.rsp_valid, bus.rsp_err, bus.rsp_data);
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid();
    logic bad;
    bus.req_addr[0] = DRP_ADDR_AUX15;
    bus.req_valid   = 4'b0001;
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if ({bus.req_ready, bus.rsp_valid, bus.drp_den, bus.drp_daddr, bus.rsp_data, bus.rsp_err} !== '0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_outputs: got ready=%b rsp=%b den=%b addr=%h data=%h err=%b expected all 0",
               bus.req_ready, bus.rsp_valid, bus.drp_den, bus.drp_daddr, bus.rsp_data, bus.rsp_err);
    end
    @(negedge clk);
    bus.drp_drdy = 1'b1;
    bus.drp_do   = 16'hFFFF;
    @(negedge clk);
    bus.drp_drdy = 1'b0;
    bad = 1'b0;
    repeat (3) begin
      if (bus.rsp_valid !== 4'b0000 || bus.rsp_data !== 16'h0000) bad = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_late_drdy: got rsp_valid=%b data=%h expected 0000/0000", bus.rsp_valid, bus.rsp_data);
    end
    bus.req_valid = 4'b1111;
    @(negedge clk);
    bus.req_valid = '0;
    vectors++;
    if (bus.req_ready !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_next_grant: got %b expected 0001", bus.req_ready);
    end
    @(negedge clk);
    bus.drp_drdy = 1'b1;
    bus.drp_do   = 16'h4242;
    @(negedge clk);
    bus.drp_drdy = 1'b0;
    vectors++;
    if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 16'h4242) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_recover: got %b/%h expected 0001/4242", bus.rsp_valid, bus.rsp_data);
    end
    @(negedge clk);
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.drp_drdy  = 1'b0;
    bus.drp_do    = '0;
    test_reset();
    test_single();
    test_fairness();
    test_repeat_winner();
    test_spurious_drdy();
`ifdef XADC_DRP_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/xadc_drp_arbiter.md
XADC_DRP_ARBITER -- requirements
Module: xadc_drp_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (range 2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 64, giving the maximum WAIT cycles before an error response.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, the same clock as the XADC dclk_in.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ bits: per-requester read request.
REQ-006 The block SHALL have port req_addr, input, NUM_REQ x 7 bits: per-requester DRP address.
REQ-007 The block SHALL have port req_ready, output, NUM_REQ bits: one-cycle grant/accept pulse to the winning requester.
REQ-008 The block SHALL have port rsp_valid, output, NUM_REQ bits: one-cycle response pulse to the granted requester.
REQ-009 The block SHALL have port rsp_data, output, 16 bits: read data, shared by all requesters and qualified by rsp_valid.
REQ-010 The block SHALL have port rsp_err, output, 1 bit: timeout flag, qualified by rsp_valid.
REQ-011 The block SHALL have ports drp_den (output, 1), drp_daddr (output, 7), drp_dwe (output, 1, tied 0) and drp_di (output, 16, tied 0) towards the XADC.
REQ-012 The block SHALL have ports drp_do (input, 16) and drp_drdy (input, 1) from the XADC.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-014 In IDLE with any req_valid bit set, the block SHALL select a winner round-robin and pulse req_ready[winner] for one cycle.
  - Search starts at the index after the last winner.
  - The winner's req_addr is latched.
  - The FSM then moves to ISSUE.
REQ-015 In ISSUE the block SHALL assert drp_den for exactly one cycle with drp_daddr equal to the latched address, then move to WAIT.
REQ-016 In WAIT, on drp_drdy=1 the block SHALL latch drp_do into rsp_data and move to RESP.
REQ-017 In RESP the block SHALL pulse rsp_valid[winner] for one cycle, then return to IDLE.
REQ-018 Latency SHALL be as follows:
  - req_ready occurs in the cycle after req_valid is first seen in IDLE.
  - drp_den occurs 1 cycle after req_ready.
  - rsp_valid occurs 1 cycle after the drp_drdy cycle.
REQ-019 Only one transaction SHALL be outstanding at a time.
  - req_valid is ignored outside IDLE.
  - A requester holds req_valid until it receives req_ready.
REQ-020 drp_drdy asserted outside WAIT SHALL be ignored and SHALL NOT change state or rsp_data.
REQ-021 The round-robin pointer SHALL update only on grant, and SHALL wrap from NUM_REQ-1 to 0.
REQ-022 If the previous winner is the only active requester, it SHALL be granted again.
REQ-023 drp_daddr SHALL hold the latched address at all times other than reset, so that it is stable through WAIT.

Reset
REQ-024 While reset is high, the block SHALL go to IDLE and drive all outputs as follows:
  - drp_den=0, drp_daddr=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0.
  - The round-robin pointer is reset so that requester 0 has first priority.
REQ-025 Reset mid-transaction SHALL abandon the transaction with no rsp_valid, and any later drp_drdy SHALL be ignored.

Configuration
REQ-026 With macro XADC_DRP_TIMEOUT_EN defined, a WAIT-cycle counter SHALL run, and after TIMEOUT_CYCLES cycles without drp_drdy the FSM SHALL go to RESP with rsp_err=1 and rsp_data=16'h0000.
REQ-027 If drp_drdy arrives in the terminal timeout cycle, the data SHALL take priority and rsp_err SHALL be 0.
REQ-028 Without XADC_DRP_TIMEOUT_EN, WAIT SHALL persist until drp_drdy, the counter SHALL be absent, and rsp_err SHALL be tied to 0 with the port retained.

Structure
REQ-029 Package xadc_drp_pkg SHALL hold:
  - the state enum typedef;
  - DRP address constants, including AUX15 = 7'h1F, TEMP = 7'h00 and VCCINT = 7'h01;
  - the DRP data width of 16.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter with inputs req[NUM_REQ] and a pointer, and outputs a one-hot grant and an index.

Verification
REQ-031 Single requester: req_valid=4'b0001, addr 7'h1F, drp_drdy 5 cycles after den with do 16'h8000. Required response:
  - req_ready[0] pulses once;
  - drp_den pulses once with addr 1F;
  - rsp_valid[0] occurs 1 cycle after drdy with rsp_data 8000 and rsp_err 0.
REQ-032 Fairness: all four requesters held valid for 8 transactions -> grants SHALL follow the order 0,1,2,3,0,1,2,3.
REQ-033 Spurious drp_drdy pulsed in IDLE and in ISSUE -> no rsp_valid and rsp_data unchanged.
REQ-034 Timeout (macro defined): drp_drdy never asserted -> rsp_valid exactly TIMEOUT_CYCLES cycles after entering WAIT, with rsp_err=1 and rsp_data=0. With drdy in the terminal cycle -> rsp_err=0.
REQ-035 Reset asserted in WAIT with drdy arriving 2 cycles later -> all outputs 0, no rsp_valid, and the next grant goes to requester 0.
